// File: rtl/jt51_bridge_pkg.sv
// Shared types and helpers for the jt51 sample bridge.
package jt51_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0] UNITY_GAIN = 8'h80;

  // Clamp a signed value into the signed range of the given bit width.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                               input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)      sat_s = hi;
    else if (value < lo) sat_s = lo;
    else                 sat_s = value;
  endfunction

endpackage

// File: rtl/jt51_frame_fifo.sv
// Frame FIFO: DEPTH entries of W bits, registered level/full/empty flags.
module jt51_frame_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;
  logic [LW-1:0] level_d;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  // Next occupancy; a same-cycle push and pop leave it unchanged.
  always_comb begin
    level_d = level;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

endmodule

// File: rtl/jt51_sample_bridge.sv
// jt51 multi-channel PCM frame capture -> per-channel valid/ready stream,
// sign-extended and left-aligned to OUT_W. Optional per-frame gain with
// saturation is enabled by defining JT51_BRIDGE_GAIN_EN.
module jt51_sample_bridge
  import jt51_bridge_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_stb,
  input  logic [NCH*IN_W-1:0]         din,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [OUT_W-1:0]            m_data,
  output logic [$clog2(NCH)-1:0]      m_chan,
  output logic                        m_last,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  input  logic                        clr_ovf,
  input  logic [7:0]                  gain
);

  localparam int unsigned CW    = $clog2(NCH);
  localparam int unsigned FW    = NCH * IN_W;
  localparam int unsigned SHIFT = OUT_W - IN_W;

  state_t                  state_q, state_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic                    pop, load;
  logic [FW-1:0]           fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic signed [OUT_W-1:0] ext_v    [NCH];
  logic signed [OUT_W-1:0] conv     [NCH];
  logic signed [OUT_W-1:0] shadow_q [NCH];
  logic signed [OUT_W-1:0] shadow_d [NCH];
  logic [OUT_W-1:0]        data_d;

  jt51_frame_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sample_stb),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

`ifdef JT51_BRIDGE_GAIN_EN
  localparam int unsigned PW = OUT_W + 9;
  logic signed [PW-1:0] prod_v [NCH];

  // Extend, scale by Q1.7 gain, then saturate back to OUT_W.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ext_v[i]  = OUT_W'($signed(fifo_rdata[i*IN_W +: IN_W])) <<< SHIFT;
      prod_v[i] = PW'(ext_v[i]) * $signed({1'b0, gain});
      conv[i]   = OUT_W'(sat_s(64'(prod_v[i] >>> 7), OUT_W));
    end
  end
`else
  logic unused_gain;
  assign unused_gain = ^gain;

  // Sign-extend and left-align each channel of the FIFO head frame.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ext_v[i] = OUT_W'($signed(fifo_rdata[i*IN_W +: IN_W])) <<< SHIFT;
      conv[i]  = ext_v[i];
    end
  end
`endif

  // Next state, channel index and pop/load decisions.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          chan_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_valid && m_ready) begin
          if (chan_q != CW'(NCH - 1)) begin
            chan_d = chan_q + CW'(1);
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            load   = 1'b1;
            chan_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next shadow contents and the sample selected for the next beat.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = load ? conv[i] : shadow_q[i];
      if (CW'(i) == chan_d) data_d = shadow_d[i];
    end
  end

  // FSM, shadow frame and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      shadow_q <= shadow_d;
      m_valid  <= (state_d == SEND);
      m_data   <= data_d;
      m_chan   <= chan_d;
      m_last   <= (state_d == SEND) && (chan_d == CW'(NCH - 1));
    end
  end

  // Sticky drop flag; a drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        overflow <= 1'b0;
    else if (sample_stb && fifo_full)  overflow <= 1'b1;
    else if (clr_ovf)                  overflow <= 1'b0;
  end

endmodule

// File: tb/tb_jt51_sample_bridge.sv
// Testbench for jt51_sample_bridge (default parameters).
module tb_jt51_sample_bridge;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 24;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              sample_stb;
  logic [NCH*IN_W-1:0] din;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic [0:0]        m_chan;
  logic              m_last;
  logic [2:0]        level;
  logic              overflow;
  logic              clr_ovf;
  logic [7:0]        gain;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        l;
    logic        c;
    logic [23:0] d;
  } beat_t;

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [7:0]  g;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vt[5];

  jt51_sample_bridge #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_stb (sample_stb),
    .din        (din),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .gain       (gain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference conversion: value * 2^(OUT_W-IN_W), optionally times gain/128, clamped.
  function automatic logic [23:0] conv(input logic [15:0] s, input logic [7:0] g);
    longint e;
    e = longint'($signed(s)) * 256;
`ifdef JT51_BRIDGE_GAIN_EN
    e = (e * longint'(g)) >>> 7;
    if (e > 64'sh7FFFFF)  e = 64'sh7FFFFF;
    if (e < -64'sh800000) e = -64'sh800000;
`else
    if (g == 8'h00) e = e + 0;
`endif
    return 24'(e);
  endfunction

  task automatic push_frame(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] g);
    exp_q.push_back('{l: 1'b0, c: 1'b0, d: conv(s0, g)});
    exp_q.push_back('{l: 1'b1, c: 1'b1, d: conv(s1, g)});
  endtask

  function automatic logic [26:0] obs();
    return {m_valid, m_last, m_chan, m_data};
  endfunction

  // One frame through an idle bridge with m_ready high: checks latency and both beats.
  task automatic run_frame(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] g,
                           input logic [23:0] e0, input logic [23:0] e1, input string nm);
    gain       = g;
    m_ready    = 1'b1;
    din        = {s1, s0};
    sample_stb = 1'b1;
    tick;
    sample_stb = 1'b0;
    chk({nm, " cycle1 valid"}, 64'(m_valid), 64'd0);
    tick;
    chk({nm, " beat0"}, 64'(obs()), 64'({1'b1, 1'b0, 1'b0, e0}));
    tick;
    chk({nm, " beat1"}, 64'(obs()), 64'({1'b1, 1'b1, 1'b1, e1}));
    tick;
    chk({nm, " idle after"}, 64'(m_valid), 64'd0);
  endtask

  // Accept beats with m_ready high until the expected queue empties or the budget runs out.
  task automatic drain(input int budget, input string nm);
    beat_t b;
    int    n;
    m_ready    = 1'b1;
    sample_stb = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (m_valid) begin
        b = exp_q.pop_front();
        chk(nm, 64'({m_last, m_chan, m_data}), 64'(b));
      end
      tick;
      n++;
    end
    if (exp_q.size() > 0) begin
      chk({nm, " timeout beats left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [15:0] s0, s1;
    logic [26:0] prev;
    logic        hold;
    beat_t       b;

    vt[0] = '{16'h8000, 16'h7FFF, 8'h80, 24'h800000, 24'h7FFF00};
    vt[1] = '{16'h0000, 16'hFFFF, 8'h80, 24'h000000, 24'hFFFF00};
    vt[2] = '{16'h0001, 16'h1234, 8'h80, 24'h000100, 24'h123400};
`ifdef JT51_BRIDGE_GAIN_EN
    vt[3] = '{16'h4000, 16'hC000, 8'h40, 24'h200000, 24'hE00000};
    vt[4] = '{16'h7FFF, 16'h8000, 8'hFF, 24'h7FFFFF, 24'h800000};
`else
    vt[3] = '{16'h4000, 16'hC000, 8'h40, 24'h400000, 24'hC00000};
    vt[4] = '{16'h7FFF, 16'h8000, 8'hFF, 24'h7FFF00, 24'h800000};
`endif

    rst_n      = 1'b0;
    sample_stb = 1'b0;
    din        = '0;
    m_ready    = 1'b0;
    clr_ovf    = 1'b0;
    gain       = 8'h80;
    #3;
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_data", 64'(m_data), 64'd0);
    chk("reset chan/last", 64'({m_chan, m_last}), 64'd0);
    chk("reset level", 64'(level), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Conversion table
    for (int r = 0; r < 5; r++)
      run_frame(vt[r].s0, vt[r].s1, vt[r].g, vt[r].e0, vt[r].e1, $sformatf("vec%0d", r));
    gain = 8'h80;

    // Backpressure hold
    m_ready    = 1'b0;
    din        = {16'hF0F0, 16'h0A0B};
    sample_stb = 1'b1;
    tick;
    sample_stb = 1'b0;
    tick;
    chk("bp first beat", 64'(obs()), 64'({1'b1, 1'b0, 1'b0, 24'h0A0B00}));
    repeat (5) begin
      tick;
      chk("bp hold", 64'(obs()), 64'({1'b1, 1'b0, 1'b0, 24'h0A0B00}));
    end
    m_ready = 1'b1;
    tick;
    chk("bp release beat1", 64'(obs()), 64'({1'b1, 1'b1, 1'b1, 24'hF0F000}));
    tick;
    chk("bp idle after", 64'(m_valid), 64'd0);

    // Overflow: six strobes into a stalled bridge
    m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s0 = 16'(k * 16'h0101);
      s1 = 16'(16'h1000 + k * 16'h0111);
      din = {s1, s0};
      sample_stb = 1'b1;
      if (k <= 5) push_frame(s0, s1, gain);
      tick;
    end
    sample_stb = 1'b0;
    chk("ovf level full", 64'(level), 64'd4);
    chk("ovf flag set", 64'(overflow), 64'd1);
    chk("ovf shadow frame1", 64'(obs()), 64'({1'b1, 1'b0, 1'b0, conv(16'h0101, gain)}));
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    chk("ovf cleared", 64'(overflow), 64'd0);
    din        = {16'hDEAD, 16'hBEEF};
    sample_stb = 1'b1;
    clr_ovf    = 1'b1;
    tick;
    sample_stb = 1'b0;
    clr_ovf    = 1'b0;
    chk("ovf set beats clear", 64'(overflow), 64'd1);
    chk("ovf level still full", 64'(level), 64'd4);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    chk("ovf cleared again", 64'(overflow), 64'd0);
    drain(60, "ovf drain");
    tick;
    chk("ovf drained level", 64'(level), 64'd0);
    chk("ovf drained valid", 64'(m_valid), 64'd0);

    // Asynchronous reset while streaming
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din        = {16'(16'h2200 + k), 16'(16'h3300 + k)};
      sample_stb = 1'b1;
      tick;
    end
    sample_stb = 1'b0;
    chk("rst pre level", 64'(level), 64'd3);
    chk("rst pre valid", 64'(m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async valid", 64'(m_valid), 64'd0);
    chk("rst async level", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    run_frame(16'h0F00, 16'hF00F, 8'h80, 24'h0F0000, 24'hF00F00, "post reset");
    chk("post reset level", 64'(level), 64'd0);

    // Randomized traffic against the queue model
    hold = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ((cyc % 100) < 50) m_ready = ($urandom_range(3) != 0);
      else                  m_ready = ($urandom_range(3) == 0);
      if ($urandom_range(2) == 0 && level < 3'(DEPTH)) begin
        s0  = 16'($urandom);
        s1  = 16'($urandom);
        din = {s1, s0};
        sample_stb = 1'b1;
        push_frame(s0, s1, gain);
      end else begin
        sample_stb = 1'b0;
      end
      if (hold) chk("rand hold stable", 64'(obs()), 64'(prev));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand spurious beat", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("rand beat", 64'({m_last, m_chan, m_data}), 64'(b));
        end
      end
      hold = m_valid && !m_ready;
      prev = obs();
      tick;
    end
    sample_stb = 1'b0;
    drain(200, "rand drain");
    tick;
    chk("rand end level", 64'(level), 64'd0);
    chk("rand end overflow", 64'(overflow), 64'd0);
    chk("rand end valid", 64'(m_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
